ccu_ar_scheduler: RTL and testbench

- Shares the single CCU read-address channel between NoPorts core-side requesters, using round-robin arbitration.
- Tags each granted request with its port index in the upper ID bits.
- Routes read-data beats back to the originating port by decoding those bits.
- Enforces a per-port outstanding-read limit; sits between the per-core dispatch stage and the CCU read path.

---
 rtl/ccu_ar_scheduler.sv | 164 ++++++++++++++++
 tb/tb_ccu_ar_scheduler.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccu_ar_scheduler.sv
// Round-robin arbiter sharing the CCU read-address channel between core ports.
// Tags grants with the port index in the upper ID bits and routes R beats back by that tag.
module ccu_ar_scheduler #(
    parameter int NoPorts        = 4,
    parameter int AddrWidth      = 64,
    parameter int IdWidth        = 4,
    parameter int DataWidth      = 64,
    parameter int MaxOutstanding = 8,
    localparam int IdxW          = (NoPorts > 1) ? $clog2(NoPorts) : 1,
    localparam int CntW          = $clog2(MaxOutstanding + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NoPorts-1:0]           slv_ar_valid_i,
    output logic [NoPorts-1:0]           slv_ar_ready_o,
    input  logic [NoPorts*IdWidth-1:0]   slv_ar_id_i,
    input  logic [NoPorts*AddrWidth-1:0] slv_ar_addr_i,
    input  logic [NoPorts*8-1:0]         slv_ar_len_i,
    output logic                         mst_ar_valid_o,
    input  logic                         mst_ar_ready_i,
    output logic [IdxW+IdWidth-1:0]      mst_ar_id_o,
    output logic [AddrWidth-1:0]         mst_ar_addr_o,
    output logic [7:0]                   mst_ar_len_o,
    input  logic                         mst_r_valid_i,
    output logic                         mst_r_ready_o,
    input  logic [IdxW+IdWidth-1:0]      mst_r_id_i,
    input  logic [DataWidth-1:0]         mst_r_data_i,
    input  logic                         mst_r_last_i,
    output logic [NoPorts-1:0]           slv_r_valid_o,
    input  logic [NoPorts-1:0]           slv_r_ready_i,
    output logic [IdWidth-1:0]           slv_r_id_o,
    output logic [DataWidth-1:0]         slv_r_data_o,
    output logic                         slv_r_last_o,
    output logic                         busy_o
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 rr_q, rr_d;
    logic [IdxW-1:0]                 gnt_q, gnt_d;
    logic [NoPorts-1:0][CntW-1:0]    cnt_q, cnt_d;
    logic                            busy_q, busy_d;

    logic                            found;
    logic [IdxW-1:0]                 sel;
    logic [IdxW-1:0]                 cur;
    logic                            req;
    logic                            ar_hs;
    logic [IdxW-1:0]                 r_port;
    logic                            r_in_range;
    logic                            r_last_hs;

    // Round-robin scan from rr_q; only ports below their in-flight limit qualify.
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int k = 0; k < NoPorts; k++) begin
            j = (int'(rr_q) + k) % NoPorts;
            if (!found && slv_ar_valid_i[j] && (cnt_q[j] < CntW'(MaxOutstanding))) begin
                found = 1'b1;
                sel   = IdxW'(j);
            end
        end
    end

    // A stalled grant stays locked so valid and payload remain stable until accepted.
    always_comb begin
        int ci;
        if (state_q == LOCKED) begin
            cur = gnt_q;
            req = 1'b1;
        end else begin
            cur = sel;
            req = found;
        end
        if (rst_i) begin
            req = 1'b0;
        end
        ci             = int'(cur);
        ar_hs          = req && mst_ar_ready_i;
        mst_ar_valid_o = req;
        mst_ar_id_o    = {cur, slv_ar_id_i[ci*IdWidth +: IdWidth]};
        mst_ar_addr_o  = slv_ar_addr_i[ci*AddrWidth +: AddrWidth];
        mst_ar_len_o   = slv_ar_len_i[ci*8 +: 8];
        slv_ar_ready_o = '0;
        if (ar_hs) begin
            slv_ar_ready_o[cur] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        if (req) begin
            if (mst_ar_ready_i) begin
                state_d = IDLE;
                rr_d    = (int'(cur) == NoPorts - 1) ? '0 : cur + IdxW'(1);
            end else begin
                state_d = LOCKED;
                gnt_d   = cur;
            end
        end
    end

    // Unbuffered R demux; beats tagged with a nonexistent port are sunk.
    always_comb begin
        r_port         = mst_r_id_i[IdxW+IdWidth-1:IdWidth];
        r_in_range     = (int'(r_port) < NoPorts);
        slv_r_valid_o  = '0;
        mst_r_ready_o  = 1'b1;
        if (r_in_range) begin
            slv_r_valid_o[r_port] = mst_r_valid_i;
            mst_r_ready_o         = slv_r_ready_i[r_port];
        end
        slv_r_id_o   = mst_r_id_i[IdWidth-1:0];
        slv_r_data_o = mst_r_data_i;
        slv_r_last_o = mst_r_last_i;
        r_last_hs    = mst_r_valid_i && mst_r_ready_o && mst_r_last_i && r_in_range;
    end

    always_comb begin
        logic inc;
        logic dec;
        cnt_d  = cnt_q;
        busy_d = 1'b0;
        inc    = 1'b0;
        dec    = 1'b0;
        for (int i = 0; i < NoPorts; i++) begin
            inc = ar_hs && (int'(cur) == i);
            dec = r_last_hs && (int'(r_port) == i);
            if (inc && !dec && (cnt_q[i] != CntW'(MaxOutstanding))) begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end else if (dec && !inc && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end
            if (cnt_q[i] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_ccu_ar_scheduler.sv
// Self-checking bench for ccu_ar_scheduler: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_ccu_ar_scheduler;

    localparam int NP   = 4;
    localparam int AW   = 64;
    localparam int IW   = 4;
    localparam int DW   = 64;
    localparam int MAXO = 3;
    localparam int XW   = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      ar_valid;
    logic [NP-1:0]      ar_ready;
    logic [NP*IW-1:0]   ar_id;
    logic [NP*AW-1:0]   ar_addr;
    logic [NP*8-1:0]    ar_len;
    logic               m_ar_valid;
    logic               m_ar_ready;
    logic [XW+IW-1:0]   m_ar_id;
    logic [AW-1:0]      m_ar_addr;
    logic [7:0]         m_ar_len;
    logic               r_valid;
    logic               m_r_ready;
    logic [XW+IW-1:0]   r_id;
    logic [DW-1:0]      r_data;
    logic               r_last;
    logic [NP-1:0]      s_r_valid;
    logic [NP-1:0]      s_r_ready;
    logic [IW-1:0]      s_r_id;
    logic [DW-1:0]      s_r_data;
    logic               s_r_last;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int m_cnt[NP];
    int m_rr;
    bit m_lock;
    int m_gnt;
    bit m_busy;

    // Model predictions for the current cycle
    bit            e_valid;
    int            e_g;
    logic [NP-1:0] e_ar_ready;
    logic [NP-1:0] e_r_valid;
    bit            e_r_ready;

    always #5 clk = ~clk;

    ccu_ar_scheduler #(
        .NoPorts(NP), .AddrWidth(AW), .IdWidth(IW), .DataWidth(DW), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready), .slv_ar_id_i(ar_id),
        .slv_ar_addr_i(ar_addr), .slv_ar_len_i(ar_len),
        .mst_ar_valid_o(m_ar_valid), .mst_ar_ready_i(m_ar_ready), .mst_ar_id_o(m_ar_id),
        .mst_ar_addr_o(m_ar_addr), .mst_ar_len_o(m_ar_len),
        .mst_r_valid_i(r_valid), .mst_r_ready_o(m_r_ready), .mst_r_id_i(r_id),
        .mst_r_data_i(r_data), .mst_r_last_i(r_last),
        .slv_r_valid_o(s_r_valid), .slv_r_ready_i(s_r_ready), .slv_r_id_o(s_r_id),
        .slv_r_data_o(s_r_data), .slv_r_last_o(s_r_last), .busy_o(busy)
    );

    task automatic idle_inputs();
        ar_valid   = '0;
        m_ar_ready = 1'b0;
        r_valid    = 1'b0;
        r_id       = '0;
        r_data     = '0;
        r_last     = 1'b0;
        s_r_ready  = '0;
    endtask

    task automatic load_payloads();
        for (int i = 0; i < NP; i++) begin
            ar_id[i*IW +: IW]   = IW'($urandom);
            ar_addr[i*AW +: AW] = {$urandom, $urandom};
            ar_len[i*8 +: 8]    = 8'($urandom);
        end
    endtask

    // Expected outputs from the arbitration rules applied to current inputs.
    task automatic predict();
        int p;
        e_valid = 1'b0;
        e_g     = 0;
        if (m_lock) begin
            e_valid = 1'b1;
            e_g     = m_gnt;
        end else begin
            for (int k = 0; k < NP; k++) begin
                int i;
                i = (m_rr + k) % NP;
                if (!e_valid && ar_valid[i] && m_cnt[i] < MAXO) begin
                    e_valid = 1'b1;
                    e_g     = i;
                end
            end
        end
        if (rst) e_valid = 1'b0;
        e_ar_ready = '0;
        if (e_valid && m_ar_ready) e_ar_ready[e_g] = 1'b1;
        p = int'(r_id[IW +: XW]);
        e_r_valid    = '0;
        e_r_valid[p] = r_valid;
        e_r_ready    = s_r_ready[p];
    endtask

    task automatic settle();
        @(negedge clk);
        predict();
    endtask

    // Advance the clock and the model together; inputs are unchanged since settle().
    task automatic tick();
        int d[NP];
        bit nb;
        int p;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NP; i++) m_cnt[i] = 0;
            m_rr = 0; m_lock = 1'b0; m_gnt = 0; m_busy = 1'b0;
        end else begin
            nb = 1'b0;
            for (int i = 0; i < NP; i++) begin
                d[i] = 0;
                if (m_cnt[i] != 0) nb = 1'b1;
            end
            if (e_valid && m_ar_ready) d[e_g] += 1;
            p = int'(r_id[IW +: XW]);
            if (r_valid && e_r_ready && r_last) d[p] -= 1;
            for (int i = 0; i < NP; i++) begin
                m_cnt[i] += d[i];
                if (m_cnt[i] < 0) m_cnt[i] = 0;
                if (m_cnt[i] > MAXO) m_cnt[i] = MAXO;
            end
            if (e_valid) begin
                if (m_ar_ready) begin
                    m_rr = (e_g + 1) % NP; m_lock = 1'b0;
                end else begin
                    m_lock = 1'b1; m_gnt = e_g;
                end
            end
            m_busy = nb;
        end
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        s_r_ready = '1;
        for (int i = 0; i < NP; i++) begin
            for (int n = 0; n < MAXO + 1 && m_cnt[i] > 0; n++) begin
                r_valid = 1'b1; r_last = 1'b1;
                r_id    = {XW'(i), IW'($urandom)};
                settle(); tick();
            end
        end
        idle_inputs();
        settle(); tick();
        settle(); tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        load_payloads();
        rst      = 1'b1;
        ar_valid = '1;
        settle();
        n_chk++;
        if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ar_valid: got %0b expected 0", m_ar_valid); end
        n_chk++;
        if (ar_ready !== '0) begin n_fail++; $display("FAIL reset_ar_ready: got %b expected 0000", ar_ready); end
        tick();
        rst      = 1'b0;
        ar_valid = '0;
        settle();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_chk++;
        if (m_ar_valid !== 1'b0) begin n_fail++; $display("FAIL reset_idle_valid: got %0b expected 0", m_ar_valid); end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        idle_inputs();
        load_payloads();
        ar_valid   = '1;
        m_ar_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            settle();
            n_chk++;
            if (m_ar_valid !== 1'b1 || int'(m_ar_id[IW +: XW]) != exp_seq[c]) begin
                n_fail++; $display("FAIL rr_grant%0d: got valid=%0b idx=%0d expected idx=%0d", c, m_ar_valid, m_ar_id[IW +: XW], exp_seq[c]);
            end
            n_chk++;
            if (m_ar_addr !== ar_addr[exp_seq[c]*AW +: AW] || m_ar_id[IW-1:0] !== ar_id[exp_seq[c]*IW +: IW]) begin
                n_fail++; $display("FAIL rr_payload%0d: got addr=%0h id=%0h", c, m_ar_addr, m_ar_id);
            end
            n_chk++;
            if (ar_ready !== NP'(1 << exp_seq[c])) begin
                n_fail++; $display("FAIL rr_ready%0d: got %b expected one-hot %0d", c, ar_ready, exp_seq[c]);
            end
            tick();
        end
        drain();
    endtask

    task automatic test_lock();
        logic [AW-1:0] a1;
        idle_inputs();
        load_payloads();
        a1 = 64'h1000;
        ar_addr[1*AW +: AW] = a1;
        ar_valid[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) ar_valid[0] = 1'b1;
            settle();
            n_chk++;
            if (m_ar_valid !== 1'b1 || m_ar_addr !== a1 || m_ar_id[IW +: XW] !== 2'd1 || ar_ready !== '0) begin
                n_fail++; $display("FAIL lock_hold%0d: got valid=%0b addr=%0h idx=%0d ready=%b", c, m_ar_valid, m_ar_addr, m_ar_id[IW +: XW], ar_ready);
            end
            tick();
        end
        m_ar_ready = 1'b1;
        settle();
        n_chk++;
        if (ar_ready !== 4'b0010 || m_ar_addr !== a1) begin
            n_fail++; $display("FAIL lock_accept: got ready=%b addr=%0h expected 0010 addr 1000", ar_ready, m_ar_addr);
        end
        tick();
        ar_valid[1] = 1'b0;
        settle();
        n_chk++;
        if (ar_ready !== 4'b0001 || m_ar_id[IW +: XW] !== 2'd0) begin
            n_fail++; $display("FAIL lock_next: got ready=%b idx=%0d expected 0001 idx 0", ar_ready, m_ar_id[IW +: XW]);
        end
        tick();
        drain();
    endtask

    task automatic test_limit();
        idle_inputs();
        load_payloads();
        ar_valid[2] = 1'b1;
        m_ar_ready  = 1'b1;
        for (int c = 0; c < MAXO; c++) begin
            settle();
            n_chk++;
            if (ar_ready !== 4'b0100) begin n_fail++; $display("FAIL limit_fill%0d: got %b expected 0100", c, ar_ready); end
            tick();
        end
        ar_valid[3] = 1'b1;
        settle();
        n_chk++;
        if (m_ar_valid !== 1'b1 || ar_ready !== 4'b1000) begin
            n_fail++; $display("FAIL limit_other_port: got valid=%0b ready=%b expected 1000", m_ar_valid, ar_ready);
        end
        tick();
        ar_valid[3] = 1'b0;
        settle();
        n_chk++;
        if (m_ar_valid !== 1'b0 || ar_ready !== '0) begin
            n_fail++; $display("FAIL limit_block: got valid=%0b ready=%b expected 0", m_ar_valid, ar_ready);
        end
        tick();
        r_valid = 1'b1; r_last = 1'b1; r_id = {2'd2, 4'h9}; s_r_ready = 4'b0100;
        settle();
        n_chk++;
        if (m_ar_valid !== 1'b0 || m_r_ready !== 1'b1) begin
            n_fail++; $display("FAIL limit_release_same: got valid=%0b r_ready=%0b expected 0/1", m_ar_valid, m_r_ready);
        end
        tick();
        r_valid = 1'b0; r_last = 1'b0;
        settle();
        n_chk++;
        if (m_ar_valid !== 1'b1 || ar_ready !== 4'b0100) begin
            n_fail++; $display("FAIL limit_release_next: got valid=%0b ready=%b expected 0100", m_ar_valid, ar_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_r_route();
        logic [DW-1:0] d;
        idle_inputs();
        d = {$urandom, $urandom};
        r_valid = 1'b1; r_last = 1'b1; r_id = {2'd3, 4'h5}; r_data = d; s_r_ready = 4'b0111;
        settle();
        n_chk++;
        if (s_r_valid !== 4'b1000 || s_r_id !== 4'h5 || m_r_ready !== 1'b0) begin
            n_fail++; $display("FAIL route_stall: got valid=%b id=%0h ready=%0b expected 1000/5/0", s_r_valid, s_r_id, m_r_ready);
        end
        n_chk++;
        if (s_r_data !== d || s_r_last !== 1'b1) begin
            n_fail++; $display("FAIL route_data: got data=%0h last=%0b expected %0h/1", s_r_data, s_r_last, d);
        end
        tick();
        s_r_ready = 4'b1000;
        settle();
        n_chk++;
        if (m_r_ready !== 1'b1) begin n_fail++; $display("FAIL route_accept: got %0b expected 1", m_r_ready); end
        tick();
        idle_inputs();
        settle(); tick();
        settle();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL route_no_underflow: busy got %0b expected 0", busy); end
        tick();
    endtask

    task automatic test_back_to_back_inc_dec();
        idle_inputs();
        load_payloads();
        ar_valid[0] = 1'b1; m_ar_ready = 1'b1;
        settle(); tick();
        r_valid = 1'b1; r_last = 1'b1; r_id = {2'd0, 4'h1}; s_r_ready = 4'b0001;
        settle();
        n_chk++;
        if (ar_ready !== 4'b0001 || m_r_ready !== 1'b1) begin
            n_fail++; $display("FAIL simul_hs: got ar_ready=%b r_ready=%0b expected 0001/1", ar_ready, m_r_ready);
        end
        tick();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            settle();
            n_chk++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL simul_busy%0d: got %0b expected 1", c, busy); end
            tick();
        end
        r_valid = 1'b1; r_last = 1'b1; r_id = {2'd0, 4'h1}; s_r_ready = 4'b0001;
        settle(); tick();
        idle_inputs();
        settle(); tick();
        settle();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_cnt_kept: busy got %0b expected 0", busy); end
        tick();
    endtask

    task automatic test_reset_locked();
        idle_inputs();
        load_payloads();
        ar_valid[1] = 1'b1; m_ar_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin settle(); tick(); end
        ar_valid = 4'b0001; m_ar_ready = 1'b0;
        settle(); tick();
        rst = 1'b1; ar_valid = '0;
        settle(); tick();
        rst = 1'b0;
        settle();
        n_chk++;
        if (m_ar_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstlock_state: got valid=%0b busy=%0b expected 0/0", m_ar_valid, busy);
        end
        tick();
        r_valid = 1'b1; r_last = 1'b1; r_id = {2'd1, 4'h3}; s_r_ready = 4'b0010;
        settle(); tick();
        idle_inputs();
        settle(); tick();
        settle();
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstlock_cnt1: busy got %0b expected 0", busy); end
        tick();
        ar_valid = '1; m_ar_ready = 1'b1;
        settle();
        n_chk++;
        if (ar_ready !== 4'b0001) begin n_fail++; $display("FAIL rstlock_rr: got %b expected 0001", ar_ready); end
        tick();
        drain();
    endtask

    task automatic test_random();
        logic [XW+IW-1:0] eid;
        for (int c = 0; c < 400; c++) begin
            load_payloads();
            rst        = ($urandom_range(0, 59) == 0);
            ar_valid   = NP'($urandom);
            m_ar_ready = ($urandom_range(0, 2) != 0);
            r_valid    = $urandom_range(0, 1) == 1;
            r_id       = {XW'($urandom), IW'($urandom)};
            r_data     = {$urandom, $urandom};
            r_last     = $urandom_range(0, 1) == 1;
            s_r_ready  = NP'($urandom);
            settle();
            n_chk++;
            if (m_ar_valid !== e_valid || ar_ready !== e_ar_ready) begin
                n_fail++; $display("FAIL rand_ar%0d: got valid=%0b ready=%b expected %0b/%b", c, m_ar_valid, ar_ready, e_valid, e_ar_ready);
            end
            if (e_valid) begin
                eid = {XW'(e_g), ar_id[e_g*IW +: IW]};
                n_chk++;
                if (m_ar_id !== eid || m_ar_addr !== ar_addr[e_g*AW +: AW] || m_ar_len !== ar_len[e_g*8 +: 8]) begin
                    n_fail++; $display("FAIL rand_payload%0d: got id=%0h addr=%0h len=%0h expected id=%0h", c, m_ar_id, m_ar_addr, m_ar_len, eid);
                end
            end
            n_chk++;
            if (s_r_valid !== e_r_valid || m_r_ready !== e_r_ready || s_r_id !== r_id[IW-1:0] || s_r_data !== r_data || s_r_last !== r_last) begin
                n_fail++; $display("FAIL rand_r%0d: got valid=%b ready=%0b id=%0h expected %b/%0b/%0h", c, s_r_valid, m_r_ready, s_r_id, e_r_valid, e_r_ready, r_id[IW-1:0]);
            end
            n_chk++;
            if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy%0d: got %0b expected %0b", c, busy, m_busy); end
            tick();
        end
        rst = 1'b0;
        drain();
    endtask

    initial begin
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        m_rr = 0; m_lock = 1'b0; m_gnt = 0; m_busy = 1'b0;
        ar_id = '0; ar_addr = '0; ar_len = '0;
        rst = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_round_robin();
        test_lock();
        test_limit();
        test_r_route();
        test_back_to_back_inc_dec();
        test_reset_locked();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
